// File: rtl/wts_channel_mixer_if.sv
// Channel-mixer bus: per-channel request/sample inputs from the upstream voices
// and the mixed output. The mixer takes the slave side of this bus.
interface wts_channel_mixer_if;
  logic               active;
  logic [2:0]         ch_sel;
  logic signed [7:0]  ch_sample;
  logic [7:0]         ch_envelope;
  logic [3:0]         ch_volume;
  logic signed [9:0]  mix_out;
  logic               mix_valid;

  modport master (
    output active, ch_sample, ch_envelope, ch_volume,
    input  ch_sel, mix_out, mix_valid
  );

  modport slave (
    input  active, ch_sample, ch_envelope, ch_volume,
    output ch_sel, mix_out, mix_valid
  );
endinterface

// File: rtl/wts_channel_mixer.sv
// Time-multiplexed wavetable channel mixer: envelope/volume scaling and frame accumulation.
// Optional macro WTS_MIXER_SATURATE_EN selects a clamped full-scale output instead of a halved one.
module wts_channel_mixer #(
  parameter int CH_NUM = 5
) (
  input  logic                clk,
  input  logic                reset,
  wts_channel_mixer_if.slave  mix_if
);

  localparam logic [2:0] LAST_IDX = 3'(CH_NUM - 1);

  logic [2:0]         ch_sel_q, ch_sel_d;
  logic signed [8:0]  a_val_q, a_val_d;
  logic [3:0]         a_vol_q, a_vol_d;
  logic [2:0]         a_idx_q, a_idx_d;
  logic               a_valid_q, a_valid_d;
  logic signed [10:0] acc_q, acc_d;
  logic               frame_ok_q, frame_ok_d;
  logic signed [9:0]  mix_out_q, mix_out_d;
  logic               mix_valid_q, mix_valid_d;

  logic [7:0]         env_clamped;
  logic signed [16:0] sample_ext;
  logic signed [16:0] env_ext;
  logic signed [16:0] prod_a;
  logic signed [12:0] val_ext;
  logic signed [12:0] vol_ext;
  logic signed [12:0] prod_c;
  logic signed [10:0] contrib;
  logic signed [10:0] final_sum;
  logic signed [9:0]  mix_value;
  logic               frame_complete;

  // Stage A: envelope scaling of the currently selected channel.
  always_comb begin
    env_clamped = (mix_if.ch_envelope > 8'd128) ? 8'd128 : mix_if.ch_envelope;
    sample_ext  = 17'(mix_if.ch_sample);
    env_ext     = 17'(env_clamped);
    prod_a      = sample_ext * env_ext;
  end

  // Stage B: volume scaling of the captured value and frame summation.
  always_comb begin
    val_ext   = 13'(a_val_q);
    vol_ext   = 13'(a_vol_q);
    prod_c    = val_ext * vol_ext;
    contrib   = 11'(prod_c >>> 4);
    final_sum = (a_idx_q == 3'd0) ? contrib : acc_q + contrib;
  end

  always_comb begin
    mix_value = '0;
`ifdef WTS_MIXER_SATURATE_EN
    if (final_sum > 11'sd511) begin
      mix_value = 10'sd511;
    end else if (final_sum < -11'sd512) begin
      mix_value = -10'sd512;
    end else begin
      mix_value = 10'(final_sum);
    end
`else
    mix_value = 10'(final_sum >>> 1);
`endif
  end

  // A frame may only be emitted if its channel 0 was captured since reset.
  assign frame_complete = (a_idx_q == LAST_IDX) && ((a_idx_q == 3'd0) || frame_ok_q);

  always_comb begin
    ch_sel_d    = ch_sel_q;
    a_val_d     = a_val_q;
    a_vol_d     = a_vol_q;
    a_idx_d     = a_idx_q;
    a_valid_d   = a_valid_q;
    acc_d       = acc_q;
    frame_ok_d  = frame_ok_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;

    if (mix_if.active) begin
      ch_sel_d  = (ch_sel_q == LAST_IDX) ? 3'd0 : ch_sel_q + 3'd1;
      a_val_d   = 9'(prod_a >>> 7);
      a_vol_d   = mix_if.ch_volume;
      a_idx_d   = ch_sel_q;
      a_valid_d = 1'b1;

      if (a_valid_q) begin
        acc_d = final_sum;
        if (a_idx_q == 3'd0) begin
          frame_ok_d = 1'b1;
        end
        if (frame_complete) begin
          mix_out_d   = mix_value;
          mix_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_sel_q    <= '0;
      a_val_q     <= '0;
      a_vol_q     <= '0;
      a_idx_q     <= '0;
      a_valid_q   <= 1'b0;
      acc_q       <= '0;
      frame_ok_q  <= 1'b0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      ch_sel_q    <= ch_sel_d;
      a_val_q     <= a_val_d;
      a_vol_q     <= a_vol_d;
      a_idx_q     <= a_idx_d;
      a_valid_q   <= a_valid_d;
      acc_q       <= acc_d;
      frame_ok_q  <= frame_ok_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign mix_if.ch_sel    = ch_sel_q;
  assign mix_if.mix_out   = mix_out_q;
  assign mix_if.mix_valid = mix_valid_q;

endmodule

// File: doc/wts_channel_mixer.md
WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

Interface
REQ-001 SHALL provide parameter: CH_NUM, 5, number of time-multiplexed channels, legal range 1..8.
REQ-002 SHALL provide ports, one per line, as follows:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- active  input  1  3.579MHz timing pulse; all state advances only when active=1.
- ch_sel  output  3  channel index presented to upstream (0..CH_NUM-1).
- ch_sample  input  8  signed wave sample of channel ch_sel, combinational from upstream.
- ch_envelope  input  8  envelope level of channel ch_sel (0..128 nominal).
- ch_volume  input  4  channel volume 0..15.
- mix_out  output  10  signed mixed sample.
- mix_valid  output  1  one-clk pulse marking a new mix_out.

Function
REQ-003 SHALL advance ch_sel by 1 on each clk edge with active=1, wrapping from CH_NUM-1 to 0.
REQ-004 SHALL clamp ch_envelope values above 128 to 128 before use.
REQ-005 SHALL compute stage A on the active edge where ch_sel=i: a_val <= (ch_sample * env) >>> 7 (9-bit signed, floor); also register ch_volume, index i and a_valid=1.
REQ-006 SHALL compute contrib = (a_val * a_vol) >>> 4 (floor, range -120..119).
REQ-007 SHALL update an 11-bit signed accumulator on each active edge with a_valid=1: load contrib if a_idx=0, else add contrib.
REQ-008 SHALL, on the active edge where a_valid=1 and a_idx=CH_NUM-1, register final = acc+contrib (or contrib when CH_NUM=1) into mix_out.
REQ-008 SHALL assert mix_valid for exactly one clk following the edge in REQ-008, then deassert regardless of active.
REQ-009 SHALL give latency of one active pulse: ch_sel=CH_NUM-1 at active pulse n yields mix_valid after active pulse n+1; one output per CH_NUM active pulses.
REQ-010 SHALL hold all registers, ch_sel and mix_out unchanged while active=0 (mix_valid excepted, per REQ-008).
REQ-011 SHALL never emit mix_valid for a frame whose channel 0 was not captured after reset (partial frame suppressed).
REQ-012 SHALL not overflow the accumulator for any input at CH_NUM<=8 (|sum|<=960).

Reset
REQ-013 SHALL, when reset=1 at a clk edge, clear ch_sel=0, a_val=0, a_vol=0, a_idx=0, a_valid=0, acc=0, mix_out=0 and mix_valid=0; reset overrides active.
REQ-014 SHALL discard any partial frame on reset mid-operation; first mix_valid after release follows CH_NUM+1 active pulses.

Configuration
REQ-015 SHALL honour macro WTS_MIXER_SATURATE_EN: defined -> mix_out = final clamped to [-512, 511]; undefined -> mix_out = final >>> 1 (floor, no clamp).

Verification
REQ-016 SHALL cover, with CH_NUM=5:
- All channels sample=127, env=128, vol=15 -> contrib 119 each, final 595; mix_out=511 (SAT_EN) / 297 (no SAT).
- All channels sample=-128, env=128, vol=15 -> contrib -120, final -600; mix_out=-512 / -300.
- Only ch2 vol=8, sample=100, env=64; others vol=0 -> contrib 25; mix_out=25 / 12.
- Only ch0 vol=15, sample=64, env=200 (clamped 128) -> mix_out=60 / 30.
- Reset asserted at ch_sel=3 mid-frame -> mix_valid stays 0 until 6th active pulse after release; ch_sel restarts at 0.
- active held 0 for 100 clk mid-frame -> ch_sel, mix_out frozen, no mix_valid; resumes exactly where stopped.
